// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
//   state_t  - arbiter FSM states (IDLE/ISSUE/WAIT/ACK)
//   DEF_*    - default parameter values
//   owner_w  - width of the owner index; the host is encoded as index NUM_C
//   ptr_w    - width of a core index / round-robin pointer (at least 1 bit)
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int DEF_NUM_C   = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_MEM_LAT = 1;

  function automatic int owner_w(input int num_c);
    return $clog2(num_c + 1);
  endfunction

  function automatic int ptr_w(input int num_c);
    return (num_c > 1) ? $clog2(num_c) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   - request vector, one bit per core
//   ptr   - index with highest priority this round
//   valid - at least one request present
//   grant - first requesting index at or after ptr, ascending with wrap
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] grant
);

  // Rotating a doubled copy puts the request at ptr into bit 0,
  // so a plain lowest-bit-first scan implements the wrap.
  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;

  assign dbl_s = {req, req};
  assign rot_s = N'(dbl_s >> ptr);

  // Lowest set bit of the rotated vector, mapped back to a core index.
  always_comb begin
    int sum_s;
    logic hit_s;
    valid = 1'b0;
    grant = {PW{1'b0}};
    sum_s = 0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_s = int'(ptr) + k;
      sum_s = (sum_s >= N) ? (sum_s - N) : sum_s;
      hit_s = rot_s[k] & ~valid;
      grant = hit_s ? PW'(sum_s) : grant;
      valid = valid | rot_s[k];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises NUM_C core requests plus one host request onto a
// single-port data RAM. Host has strict priority, cores are round-robin.
//   core_*  - per-core req/we/addr/wdata in, one-hot core_ack out
//   com_*   - host req/we/addr/wdata in, com_ack out
//   rdata   - read data, valid with the ack of a read
//   mem_*   - RAM strobe/write-enable/address/write-data out, mem_rdata in
//   busy    - high whenever the FSM is not in IDLE
// All outputs are registered.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_C   = DEF_NUM_C,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_C-1:0]    core_req,
  input  logic [NUM_C-1:0]    core_we,
  input  logic [NUM_C*ADDR_W-1:0] core_addr,
  input  logic [NUM_C*DATA_W-1:0] core_wdata,
  output logic [NUM_C-1:0]    core_ack,
  input  logic                com_req,
  input  logic                com_we,
  input  logic [ADDR_W-1:0]   com_addr,
  input  logic [DATA_W-1:0]   com_wdata,
  output logic                com_ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int OW = owner_w(NUM_C);
  localparam int PW = ptr_w(NUM_C);
  localparam int LW = 3;
  localparam logic [OW-1:0] HOST_ID   = OW'(NUM_C);
  localparam logic [OW-1:0] LAST_CORE = OW'(NUM_C - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(MEM_LAT - 1);

  state_t                 state_r, state_n_s;
  logic [PW-1:0]          rr_ptr_r, rr_ptr_n_s;
  logic [OW-1:0]          owner_r, owner_n_s;
  logic [LW-1:0]          lat_cnt_r, lat_cnt_n_s;
  logic                   mem_en_r, mem_en_n_s;
  logic                   mem_we_r, mem_we_n_s;
  logic [ADDR_W-1:0]      mem_addr_r, mem_addr_n_s;
  logic [DATA_W-1:0]      mem_wdata_r, mem_wdata_n_s;
  logic [DATA_W-1:0]      rdata_r, rdata_n_s;
  logic [NUM_C-1:0]       core_ack_r, core_ack_n_s;
  logic                   com_ack_r, com_ack_n_s;
  logic                   busy_r, busy_n_s;

  logic                   pick_valid_s;
  logic [PW-1:0]          pick_grant_s;
  logic                   is_host_s;
  logic [NUM_C-1:0]       own_onehot_s;
  logic [ADDR_W-1:0]      addr_arr_s  [NUM_C];
  logic [DATA_W-1:0]      wdata_arr_s [NUM_C];

  for (genvar g = 0; g < NUM_C; g++) begin : g_unpack
    assign addr_arr_s[g]  = core_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr_s[g] = core_wdata[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_C), .PW(PW)) u_rr_pick (
    .req   (core_req),
    .ptr   (rr_ptr_r),
    .valid (pick_valid_s),
    .grant (pick_grant_s)
  );

  assign is_host_s    = (owner_r == HOST_ID);
  assign own_onehot_s = is_host_s ? {NUM_C{1'b0}} : (NUM_C'(1'b1) << owner_r);

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_n_s     = state_r;
    rr_ptr_n_s    = rr_ptr_r;
    owner_n_s     = owner_r;
    lat_cnt_n_s   = lat_cnt_r;
    mem_en_n_s    = 1'b0;
    mem_we_n_s    = 1'b0;
    mem_addr_n_s  = mem_addr_r;
    mem_wdata_n_s = mem_wdata_r;
    rdata_n_s     = rdata_r;
    core_ack_n_s  = {NUM_C{1'b0}};
    com_ack_n_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (com_req) begin
          owner_n_s     = HOST_ID;
          mem_en_n_s    = 1'b1;
          mem_we_n_s    = com_we;
          mem_addr_n_s  = com_addr;
          mem_wdata_n_s = com_wdata;
          state_n_s     = ISSUE;
        end else if (pick_valid_s) begin
          owner_n_s     = OW'(pick_grant_s);
          mem_en_n_s    = 1'b1;
          mem_we_n_s    = core_we[pick_grant_s];
          mem_addr_n_s  = addr_arr_s[pick_grant_s];
          mem_wdata_n_s = wdata_arr_s[pick_grant_s];
          state_n_s     = ISSUE;
        end else begin
          state_n_s = IDLE;
        end
      end
      ISSUE: begin
        // The RAM samples at the end of this cycle; strobes drop on exit.
        if (mem_we_r) begin
          core_ack_n_s = own_onehot_s;
          com_ack_n_s  = is_host_s;
          state_n_s    = ACK;
        end else begin
          lat_cnt_n_s = {LW{1'b0}};
          state_n_s   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_r == LAT_LAST) begin
          rdata_n_s    = mem_rdata;
          core_ack_n_s = own_onehot_s;
          com_ack_n_s  = is_host_s;
          state_n_s    = ACK;
        end else begin
          lat_cnt_n_s = lat_cnt_r + LW'(1);
        end
      end
      ACK: begin
        // Host transactions leave the core rotation untouched.
        if (is_host_s) begin
          rr_ptr_n_s = rr_ptr_r;
        end else if (owner_r == LAST_CORE) begin
          rr_ptr_n_s = {PW{1'b0}};
        end else begin
          rr_ptr_n_s = PW'(owner_r + OW'(1));
        end
        state_n_s = IDLE;
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
    busy_n_s = (state_n_s != IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {PW{1'b0}};
      owner_r     <= {OW{1'b0}};
      lat_cnt_r   <= {LW{1'b0}};
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      core_ack_r  <= {NUM_C{1'b0}};
      com_ack_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      rr_ptr_r    <= rr_ptr_n_s;
      owner_r     <= owner_n_s;
      lat_cnt_r   <= lat_cnt_n_s;
      mem_en_r    <= mem_en_n_s;
      mem_we_r    <= mem_we_n_s;
      mem_addr_r  <= mem_addr_n_s;
      mem_wdata_r <= mem_wdata_n_s;
      rdata_r     <= rdata_n_s;
      core_ack_r  <= core_ack_n_s;
      com_ack_r   <= com_ack_n_s;
      busy_r      <= busy_n_s;
    end
  end

  assign core_ack  = core_ack_r;
  assign com_ack   = com_ack_r;
  assign rdata     = rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter.
// Instance a: NUM_C=4, MEM_LAT=1. Instance b: NUM_C=1, MEM_LAT=3.
// Each has a small RAM model whose read data is only valid in the exact
// cycle the latency dictates (zero otherwise).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a signals
  logic [3:0]  core_req, core_we, core_ack;
  logic [63:0] core_addr, core_wdata;
  logic        com_req, com_we, com_ack;
  logic [15:0] com_addr, com_wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, busy;

  // Instance b signals
  logic [0:0]  b_core_req, b_core_we, b_core_ack;
  logic [15:0] b_core_addr, b_core_wdata;
  logic        b_com_req, b_com_we, b_com_ack;
  logic [15:0] b_com_addr, b_com_wdata, b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_en, b_mem_we, b_busy;

  dmem_arbiter #(.NUM_C(4), .DATA_W(16), .ADDR_W(16), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack),
    .com_req(com_req), .com_we(com_we), .com_addr(com_addr),
    .com_wdata(com_wdata), .com_ack(com_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.NUM_C(1), .DATA_W(16), .ADDR_W(16), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .core_req(b_core_req), .core_we(b_core_we), .core_addr(b_core_addr),
    .core_wdata(b_core_wdata), .core_ack(b_core_ack),
    .com_req(b_com_req), .com_we(b_com_we), .com_addr(b_com_addr),
    .com_wdata(b_com_wdata), .com_ack(b_com_ack),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0020: return 16'h1234;
      16'h0030: return 16'h5A5A;
      16'h0040: return 16'hA5A5;
      default:  return 16'hDEAD;
    endcase
  endfunction

  // RAM model a: one-cycle read latency
  always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? rom(mem_addr) : 16'h0000;

  // RAM model b: three-cycle read latency
  logic [15:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_b[0] <= (b_mem_en && !b_mem_we) ? rom(b_mem_addr) : 16'h0000;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order_h [4];
    order_h = '{2, 3, 0, 1};
    rst_n = 1'b0;
    core_req = 4'b0000; core_we = 4'b0000; core_addr = 64'h0; core_wdata = 64'h0;
    com_req = 1'b0; com_we = 1'b0; com_addr = 16'h0000; com_wdata = 16'h0000;
    b_core_req = 1'b0; b_core_we = 1'b0; b_core_addr = 16'h0000; b_core_wdata = 16'h0000;
    b_com_req = 1'b0; b_com_we = 1'b0; b_com_addr = 16'h0000; b_com_wdata = 16'h0000;

    // Reset state
    repeat (2) tick();
    chk("rst_core_ack", core_ack, 4'b0000);
    chk("rst_com_ack", com_ack, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_b_busy", b_busy, 1'b0);
    rst_n = 1'b1;

    // Core 2 write 0x0010 <- 0xBEEF
    core_we[2] = 1'b1; core_addr[32 +: 16] = 16'h0010; core_wdata[32 +: 16] = 16'hBEEF;
    core_req[2] = 1'b1;
    tick();
    chk("w_mem_en", mem_en, 1'b1);
    chk("w_mem_we", mem_we, 1'b1);
    chk("w_mem_addr", mem_addr, 16'h0010);
    chk("w_mem_wdata", mem_wdata, 16'hBEEF);
    chk("w_busy_c1", busy, 1'b1);
    chk("w_no_early_ack", core_ack, 4'b0000);
    tick();
    chk("w_ack", core_ack, 4'b0100);
    chk("w_mem_en_off", mem_en, 1'b0);
    chk("w_addr_hold", mem_addr, 16'h0010);
    core_req = 4'b0000; core_we = 4'b0000;
    tick();
    chk("w_busy_c3", busy, 1'b0);
    chk("w_ack_off", core_ack, 4'b0000);
    chk("w_rdata_unch", rdata, 16'h0000);

    // Core 1 read 0x0020 (rr_ptr=3 -> scans 3,0,1)
    core_addr[16 +: 16] = 16'h0020; core_req[1] = 1'b1;
    tick();
    chk("r_mem_en", mem_en, 1'b1);
    chk("r_mem_we", mem_we, 1'b0);
    chk("r_mem_addr", mem_addr, 16'h0020);
    tick();
    chk("r_mem_en_c2", mem_en, 1'b0);
    chk("r_no_ack_c2", core_ack, 4'b0000);
    tick();
    chk("r_ack", core_ack, 4'b0010);
    chk("r_rdata", rdata, 16'h1234);
    core_req = 4'b0000;
    tick();
    chk("r_ack_off", core_ack, 4'b0000);

    // Host priority with all cores requesting, rr_ptr=2
    com_req = 1'b1; com_we = 1'b1; com_addr = 16'h0100; com_wdata = 16'hC0DE;
    core_we = 4'b1111;
    for (int i = 0; i < 4; i++) core_addr[i*16 +: 16] = 16'h0200 + 16'(i);
    core_req = 4'b1111;
    tick();
    chk("h_mem_addr", mem_addr, 16'h0100);
    chk("h_mem_wdata", mem_wdata, 16'hC0DE);
    tick();
    chk("h_com_ack", com_ack, 1'b1);
    chk("h_core_ack", core_ack, 4'b0000);
    com_req = 1'b0;
    tick();
    chk("h_com_ack_off", com_ack, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("h_core_addr", mem_addr, 16'h0200 + 16'(order_h[k]));
      tick();
      chk("h_core_order", core_ack, 4'b0001 << order_h[k]);
      if (k == 3) core_req = 4'b0000;
      tick();
      chk("h_gap", core_ack, 4'b0000);
    end
    chk("h_rdata_unch", rdata, 16'h1234);

    // Reset during WAIT of a core 3 read
    core_we = 4'b0000; core_addr[48 +: 16] = 16'h0030; core_req = 4'b1000;
    tick();
    chk("x_mem_addr", mem_addr, 16'h0030);
    tick();
    rst_n = 1'b0;
    #1;
    chk("x_core_ack", core_ack, 4'b0000);
    chk("x_mem_en", mem_en, 1'b0);
    chk("x_busy", busy, 1'b0);
    chk("x_rdata", rdata, 16'h0000);
    chk("x_mem_addr0", mem_addr, 16'h0000);
    #1;
    rst_n = 1'b1;
    tick();
    chk("x2_mem_en", mem_en, 1'b1);
    chk("x2_mem_addr", mem_addr, 16'h0030);
    chk("x2_no_ack", core_ack, 4'b0000);
    tick();
    chk("x2_no_ack_c2", core_ack, 4'b0000);
    tick();
    chk("x2_ack", core_ack, 4'b1000);
    chk("x2_rdata", rdata, 16'h5A5A);
    core_req = 4'b0000;
    tick();

    // All four cores write continuously from rr_ptr=0
    core_we = 4'b1111; core_req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("c_issue_noack", core_ack, 4'b0000);
      tick();
      chk("c_order", core_ack, 4'b0001 << (k % 4));
      if (k == 5) core_req = 4'b0000;
      tick();
      chk("c_gap", core_ack, 4'b0000);
    end

    // Single core, three-cycle latency read
    b_core_we = 1'b0; b_core_addr = 16'h0040; b_core_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("b_busy", b_busy, 1'b1);
      chk("b_ack", b_core_ack, (c == 5) ? 1'b1 : 1'b0);
      if (c == 1) chk("b_mem_en", b_mem_en, 1'b1);
      if (c == 5) begin
        chk("b_rdata", b_rdata, 16'hA5A5);
        b_core_req = 1'b0;
      end
    end
    tick();
    chk("b_busy_off", b_busy, 1'b0);
    chk("b_ack_off", b_core_ack, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shared data-memory arbiter for the multi-core processor. It serialises NUM_C core data-memory requests plus one host/communication request onto a single-port data RAM.
- Host port has strict priority; cores are served round-robin.
- Each transaction uses a request/acknowledge handshake.
- It replaces per-core memory ports and sits between the processor cores and the data RAM in the top level.

Parameters:
NUM_C, 4, number of cores (1..16)
DATA_W, 16, data word width
ADDR_W, 16, memory address width
MEM_LAT, 1, RAM read latency in cycles from the mem_en sample edge to mem_rdata valid (1..4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
core_req  in  NUM_C  per-core request, held high until matching core_ack
core_we  in  NUM_C  per-core write enable (1 = write, 0 = read)
core_addr  in  NUM_C*ADDR_W  packed per-core address, core i at [i*ADDR_W +: ADDR_W]
core_wdata  in  NUM_C*DATA_W  packed per-core write data
core_ack  out  NUM_C  one-cycle completion pulse, one-hot or zero
com_req  in  1  host request, held until com_ack
com_we  in  1  host write enable
com_addr  in  ADDR_W  host address
com_wdata  in  DATA_W  host write data
com_ack  out  1  host completion pulse
rdata  out  DATA_W  read data, valid in the cycle of any ack for a read
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, all outputs 0.
  - Applies immediately, mid-transaction included; the in-flight transaction is dropped and no ack is issued.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE (arbitration):
  - If com_req: winner = host.
  - Else if any core_req: winner = first requesting core at or after rr_ptr, scanning ascending with wrap modulo NUM_C.
  - The winner's we/addr/wdata are latched into mem_we/mem_addr/mem_wdata, mem_en is set to 1, next state is ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1 with the latched fields; the RAM samples at the end of this cycle.
  - Write: go to ACK.
  - Read: go to WAIT, lat_cnt=0.
  - On exit, mem_en and mem_we clear to 0; addr/wdata hold their values.
- WAIT (MEM_LAT cycles):
  - lat_cnt increments each cycle.
  - On the cycle where lat_cnt==MEM_LAT-1, rdata<=mem_rdata and next state is ACK.
- ACK (exactly 1 cycle):
  - core_ack[owner] or com_ack = 1.
  - On exit, rr_ptr<=(owner+1) mod NUM_C if the owner is a core; unchanged for a host transaction. Next state is IDLE.
- rdata:
  - Holds its last captured value outside reads.
  - Unchanged after writes.
- Latency, counting the cycle after the arbitration edge as cycle 1:
  - mem_en high in cycle 1.
  - Write ack in cycle 2.
  - Read ack in cycle 2+MEM_LAT.
- Minimum request spacing:
  - Write transactions: 3 cycles (IDLE, ISSUE, ACK).
  - Read transactions: 3+MEM_LAT cycles.
- Requesters must hold req, we, addr and wdata stable until their ack.
  - Fields are latched at arbitration, so later changes are ignored.
  - Dropping req early does not abort; the ack is still issued.
- A requester re-asserting req in the cycle after its ack is arbitrated normally. In IDLE its req is still sampled, so the bench must deassert in the ack cycle to avoid a double access.
- Host starvation of cores is permitted by design: the host issues only during load/unload phases.
- NUM_C=1: rr_ptr is constant 0.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/ACK).
  - Default widths.
  - Owner-index width function clog2(NUM_C+1), with the host encoded as index NUM_C.
- Sub-module rr_pick:
  - Combinational round-robin priority picker: inputs req vector and ptr; outputs valid and grant index.
  - Instantiated once in IDLE arbitration.

Test Plan:
- Core 2 writes addr 0x0010 data 0xBEEF from reset -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF; cycle 2: core_ack=4'b0100; busy low in cycle 3.
- Core 1 read addr 0x0020, RAM model returns 0x1234 with MEM_LAT=1 -> core_ack=4'b0010 in cycle 3 with rdata=0x1234; mem_en high only in cycle 1.
- All four cores hold write requests continuously -> ack order 0,1,2,3,0,1, one ack every 3 cycles.
- com_req together with core_req=4'b1111 while rr_ptr=2 -> host served first (com_ack), then cores 2,3,0,1; rr_ptr unchanged by the host transaction.
- rst_n pulsed low during WAIT of a core 3 read -> all outputs 0 immediately, no core_ack[3]; after release with core_req=4'b1000, core 3 is served first from rr_ptr=0.
- MEM_LAT=3, NUM_C=1 read returns 0xA5A5 -> core_ack=1'b1 with rdata=0xA5A5 in cycle 5; busy high in cycles 1-5.
